// File: rtl/vfifo_mc_sc_if.sv
// vfifo_mc_sc_if: bundle of the per-cycle write/read request signals and
// the registered read data / per-channel flags of vfifo_mc_sc.
//   master : producer/consumer side (drives d, wr, wr_ch, rd, rd_ch)
//   slave  : FIFO side (drives q, q_valid, full, empty)
// Optional macro VFIFO_MC_ERR_EN adds err_clr (master->slave) and the
// sticky ovf/unf flags (slave->master).
interface vfifo_mc_sc_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2
);
  localparam int NCH = 1 << CH_WIDTH;

  logic [DATA_WIDTH-1:0] d;
  logic                  wr;
  logic [CH_WIDTH-1:0]   wr_ch;
  logic                  rd;
  logic [CH_WIDTH-1:0]   rd_ch;
  logic [DATA_WIDTH-1:0] q;
  logic                  q_valid;
  logic [NCH-1:0]        full;
  logic [NCH-1:0]        empty;
`ifdef VFIFO_MC_ERR_EN
  logic                  err_clr;
  logic [NCH-1:0]        ovf;
  logic [NCH-1:0]        unf;

  modport master (
    output d, wr, wr_ch, rd, rd_ch, err_clr,
    input  q, q_valid, full, empty, ovf, unf
  );
  modport slave (
    input  d, wr, wr_ch, rd, rd_ch, err_clr,
    output q, q_valid, full, empty, ovf, unf
  );
`else
  modport master (
    output d, wr, wr_ch, rd, rd_ch,
    input  q, q_valid, full, empty
  );
  modport slave (
    input  d, wr, wr_ch, rd, rd_ch,
    output q, q_valid, full, empty
  );
`endif
endinterface

// File: rtl/vfifo_mc_sc.sv
// vfifo_mc_sc: multi-channel single-clock FIFO on one shared dual-port RAM.
// The RAM (2**ADDR_WIDTH words) is split into NCH = 2**CH_WIDTH circular
// buffers of D = 2**(ADDR_WIDTH-CH_WIDTH) words. One write and one read,
// to any channels, are accepted per cycle.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset (pointers, q, q_valid, errors)
//   bus    : vfifo_mc_sc_if.slave -- d/wr/wr_ch, rd/rd_ch in;
//            q/q_valid (registered), full/empty (per channel) out
// Optional macro VFIFO_MC_ERR_EN: adds err_clr input and sticky per-channel
// overflow (ovf) / underflow (unf) flags on the interface.
module vfifo_mc_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int CH_WIDTH   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  vfifo_mc_sc_if.slave   bus
);
  localparam int NCH   = 1 << CH_WIDTH;
  localparam int PW    = ADDR_WIDTH - CH_WIDTH;   // per-channel address bits
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [NCH-1:0][PW:0]  wr_ptr_all;
  logic [NCH-1:0][PW:0]  rd_ptr_all;
  logic [NCH-1:0]        full_w;
  logic [NCH-1:0]        empty_w;

  logic                  wr_ok;
  logic                  rd_ok;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  logic [DATA_WIDTH-1:0] q_reg;
  logic                  q_valid_reg;

  // Acceptance uses the flags as they stand before the edge, so a write to
  // an empty channel never unblocks a same-cycle read (and vice versa).
  assign wr_ok = bus.wr && !full_w[bus.wr_ch];
  assign rd_ok = bus.rd && !empty_w[bus.rd_ch];

  assign waddr = {bus.wr_ch, wr_ptr_all[bus.wr_ch][PW-1:0]};
  assign raddr = {bus.rd_ch, rd_ptr_all[bus.rd_ch][PW-1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [PW:0] wr_ptr_reg;
      logic [PW:0] rd_ptr_reg;
      logic [PW:0] wr_ptr_next;
      logic [PW:0] rd_ptr_next;
      logic        wr_hit;
      logic        rd_hit;

      assign wr_hit      = wr_ok && (bus.wr_ch == CH_WIDTH'(gi));
      assign rd_hit      = rd_ok && (bus.rd_ch == CH_WIDTH'(gi));
      assign wr_ptr_next = wr_hit ? wr_ptr_reg + {{PW{1'b0}}, 1'b1} : wr_ptr_reg;
      assign rd_ptr_next = rd_hit ? rd_ptr_reg + {{PW{1'b0}}, 1'b1} : rd_ptr_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
        end else begin
          wr_ptr_reg <= wr_ptr_next;
          rd_ptr_reg <= rd_ptr_next;
        end
      end

      assign wr_ptr_all[gi] = wr_ptr_reg;
      assign rd_ptr_all[gi] = rd_ptr_reg;

      // Wrap bit distinguishes full (D apart) from empty (equal).
      assign empty_w[gi] = (wr_ptr_reg == rd_ptr_reg);
      assign full_w[gi]  = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) &&
                           (wr_ptr_reg[PW] != rd_ptr_reg[PW]);
    end
  endgenerate

  // Write port. Read and write can never share an address in one cycle
  // (that would require the channel to be both empty and full), so no
  // read-during-write handling is needed.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= bus.d;
    end
  end

  // Registered read port; q holds until the next accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg       <= '0;
      q_valid_reg <= 1'b0;
    end else begin
      q_valid_reg <= rd_ok;
      if (rd_ok) begin
        q_reg <= mem[raddr];
      end
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.full    = full_w;
  assign bus.empty   = empty_w;

`ifdef VFIFO_MC_ERR_EN
  logic [NCH-1:0] ovf_reg;
  logic [NCH-1:0] unf_reg;

  generate
    for (gi = 0; gi < NCH; gi++) begin : g_err
      // A set in the same cycle as err_clr wins, so no event is lost.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_reg[gi] <= 1'b0;
          unf_reg[gi] <= 1'b0;
        end else begin
          if (bus.wr && (bus.wr_ch == CH_WIDTH'(gi)) && full_w[gi]) begin
            ovf_reg[gi] <= 1'b1;
          end else if (bus.err_clr) begin
            ovf_reg[gi] <= 1'b0;
          end
          if (bus.rd && (bus.rd_ch == CH_WIDTH'(gi)) && empty_w[gi]) begin
            unf_reg[gi] <= 1'b1;
          end else if (bus.err_clr) begin
            unf_reg[gi] <= 1'b0;
          end
        end
      end
    end
  endgenerate

  assign bus.ovf = ovf_reg;
  assign bus.unf = unf_reg;
`endif

endmodule

// File: tb/tb_vfifo_mc_sc.sv
// Testbench for vfifo_mc_sc (defaults: 8-bit data, 4 channels of 128 words).
// Stimulus pushes the expected word of every read that should be accepted
// into a scoreboard queue; an independent monitor pops and compares on each
// q_valid. Flags are checked directly against hand-computed values.
module tb_vfifo_mc_sc;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int CW = 2;
  localparam int D  = 1 << (AW - CW);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [DW-1:0] exp_q[$];

  vfifo_mc_sc_if #(.DATA_WIDTH(DW), .CH_WIDTH(CW)) bus ();

  vfifo_mc_sc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %b expected %b", name, act, expv);
    end
  endtask

  task automatic check1(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, expv);
    end
  endtask

  // One cycle of stimulus; exp_acc says whether the read must be accepted.
  task automatic do_op(input logic w, input logic [CW-1:0] wc, input logic [DW-1:0] dv,
                       input logic r, input logic [CW-1:0] rc,
                       input logic exp_acc, input logic [DW-1:0] expv);
    bus.wr    = w;
    bus.wr_ch = wc;
    bus.d     = dv;
    bus.rd    = r;
    bus.rd_ch = rc;
    if (exp_acc) exp_q.push_back(expv);
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  // Monitor: compares every presented word against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.q_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected got q=%h expected no q_valid", bus.q);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.q !== e) begin
          errors++;
          $display("FAIL rd_data got %h expected %h", bus.q, e);
        end else begin
          $display("rd q=%h ok", bus.q);
        end
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.d     = '0;
    bus.wr    = 1'b0;
    bus.wr_ch = '0;
    bus.rd    = 1'b0;
    bus.rd_ch = '0;
`ifdef VFIFO_MC_ERR_EN
    bus.err_clr = 1'b0;
`endif
    #2;
    check4("rst_empty", bus.empty, 4'b1111);
    check4("rst_full", bus.full, 4'b0000);
    check1("rst_q", bus.q, 8'h00);
    check4("rst_qv", {3'b000, bus.q_valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill ch2 to full, overflow attempt, then drain in order.
    for (int i = 0; i < D; i++) do_op(1'b1, 2'd2, DW'(i), 1'b0, 2'd0, 1'b0, 8'h00);
    check4("fill_full", bus.full, 4'b0100);
    check4("fill_empty", bus.empty, 4'b1011);
    do_op(1'b1, 2'd2, 8'hFF, 1'b0, 2'd0, 1'b0, 8'h00);
    check4("ovf_full", bus.full, 4'b0100);
    for (int i = 0; i < D; i++) do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b1, DW'(i));
    check4("drain_empty", bus.empty, 4'b1111);
    check4("drain_full", bus.full, 4'b0000);

    // Channel isolation.
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 2'd0, DW'(8'hA0 + i), 1'b0, 2'd0, 1'b0, 8'h00);
      do_op(1'b1, 2'd3, DW'(8'h30 + i), 1'b0, 2'd0, 1'b0, 8'h00);
    end
    check4("iso_empty", bus.empty, 4'b0110);
    check4("iso_full", bus.full, 4'b0000);
    for (int i = 0; i < 4; i++) do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b1, DW'(8'h30 + i));
    check4("iso_empty3", bus.empty, 4'b1110);
    for (int i = 0; i < 4; i++) do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, DW'(8'hA0 + i));
    check4("iso_empty_all", bus.empty, 4'b1111);

    // Simultaneous read/write on ch1 with 5 words resident; 260 cycles wraps
    // both 8-bit pointers.
    for (int i = 0; i < 5; i++) do_op(1'b1, 2'd1, DW'(8'h10 + i), 1'b0, 2'd0, 1'b0, 8'h00);
    for (int k = 0; k < 260; k++) begin
      do_op(1'b1, 2'd1, DW'(8'h15 + k), 1'b1, 2'd1, 1'b1, DW'(8'h10 + k));
      check4("rw_flags", {bus.full[1], bus.empty[1], 2'b00}, 4'b0000);
    end
    for (int i = 0; i < 5; i++) do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, DW'(8'h14 + i));
    check4("rw_empty", bus.empty, 4'b1111);

    // Write to empty ch0 with same-cycle read: read rejected.
    do_op(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 1'b0, 8'h00);
    check4("wr_empty_qv", {3'b000, bus.q_valid}, 4'b0000);
    do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b1, 8'h77);
    check4("wr_empty_qv2", {3'b000, bus.q_valid}, 4'b0001);

    // Full ch1 with wr+rd: write rejected, read accepted.
    for (int i = 0; i < D; i++) do_op(1'b1, 2'd1, DW'(i), 1'b0, 2'd0, 1'b0, 8'h00);
    check4("b_full", bus.full, 4'b0010);
`ifdef VFIFO_MC_ERR_EN
    bus.err_clr = 1'b1;
    do_op(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
    bus.err_clr = 1'b0;
    check4("err_pre_ovf", bus.ovf, 4'b0000);
    do_op(1'b1, 2'd1, 8'hFF, 1'b0, 2'd0, 1'b0, 8'h00);
    check4("err_ovf", bus.ovf, 4'b0010);
    do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 1'b0, 8'h00);
    check4("err_unf", bus.unf, 4'b1000);
    bus.err_clr = 1'b1;
    do_op(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 8'h00);
    bus.err_clr = 1'b0;
    check4("err_clr_ovf", bus.ovf, 4'b0000);
    check4("err_clr_unf", bus.unf, 4'b0000);
`endif
    do_op(1'b1, 2'd1, 8'hEE, 1'b1, 2'd1, 1'b1, 8'h00);
    check4("b_full_after", bus.full, 4'b0000);
    for (int i = 1; i < D; i++) do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b1, DW'(i));
    check4("b_drain_empty", bus.empty, 4'b1111);

    // Asynchronous reset mid-operation while q/q_valid hold live data.
    do_op(1'b1, 2'd0, 8'h55, 1'b0, 2'd0, 1'b0, 8'h00);
    do_op(1'b1, 2'd2, 8'h66, 1'b1, 2'd0, 1'b1, 8'h55);
    #6;
    rst_n = 1'b0;
    #1;
    check4("arst_empty", bus.empty, 4'b1111);
    check4("arst_full", bus.full, 4'b0000);
    check1("arst_q", bus.q, 8'h00);
    check4("arst_qv", {3'b000, bus.q_valid}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 8'h00);
    check4("post_rst_qv", {3'b000, bus.q_valid}, 4'b0000);
    check4("post_rst_empty", bus.empty, 4'b1111);

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rd_missing got %0d outstanding expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
